vga_timing: RTL
===============

Name: vga_timing

Overview:
- Raster timing generator for the Pong display pipeline. It sits directly upstream of the ball, paddle and score renderers.
- Produces pixel/line counters, hsync/vsync, an active-video flag and a per-frame tick from the system clock.
- The ball renderer consumes hcount/vcount for pixel compare. It updates its motion state once per frame on the vsync falling edge.

Parameters:
- CLK_DIV, 2, system clocks per pixel (50 MHz -> 25 MHz pixel rate); must be >= 1
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, pixels
- H_SYNC, 96, hsync pulse width, pixels
- H_BP, 48, horizontal back porch, pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, lines
- V_SYNC, 2, vsync pulse width, lines
- V_BP, 33, vertical back porch, lines
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low, VGA 640x480 standard)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- pix_tick  out  1  clock enable, high one clk per pixel period
- hcount  out  10  current pixel column, 0..H_TOTAL-1
- vcount  out  10  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level per SYNC_ACTIVE
- vsync  out  1  vertical sync, level per SYNC_ACTIVE
- video_on  out  1  high when hcount < H_ACTIVE and vcount < V_ACTIVE
- frame_tick  out  1  one-clk pulse on the edge where vsync becomes asserted

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800)
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525)
- Reset (reset_n low, asynchronous):
  - div counter = 0; hcount = 0; vcount = 0.
  - pix_tick = 0; hsync and vsync deasserted (!SYNC_ACTIVE); video_on = 0; frame_tick = 0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_tick is registered high for the single clk in which div_cnt == CLK_DIV-1.
  - With CLK_DIV = 1, pix_tick is high every clk after reset release.
- Counters advance only on clk edges where pix_tick is high:
  - hcount == H_TOTAL-1 -> hcount = 0, and vcount advances; otherwise hcount+1.
  - vcount == V_TOTAL-1 at a line wrap -> vcount = 0; otherwise vcount+1.
- Outputs are registered and are decoded from the next-state counter values. They therefore always match the hcount/vcount presented in the same cycle, with zero skew.
  - hsync asserted iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync asserted iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491). vsync changes only at a line wrap (hcount 799 -> 0).
  - video_on as defined in Ports. It stays 0 from reset until the first pix_tick, so pixel (0,0) of the first frame after reset is blanked.
- frame_tick:
  - High for exactly one clk, on the edge where vsync goes from deasserted to asserted.
  - Coincides with hcount 0, vcount 490.
  - Period is H_TOTAL*V_TOTAL*CLK_DIV clks (840000 at defaults).
- Between pix_ticks, all counters and outputs hold.
- Reset asserted mid-frame returns everything to reset values immediately, with no frame_tick generated. Counting restarts from (0,0) after release.
- Width rule: H_TOTAL-1 and V_TOTAL-1 must fit in 10 bits. An elaboration-time check fails otherwise.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN
- Defined:
  - Adds output frame_count [15:0], reset 0.
  - Increments by 1 in the same clk as frame_tick; wraps 0xFFFF -> 0.
  - Used by game logic for serve delays and score flash.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package pong_pkg:
  - default timing constants (H_ACTIVE..V_BP, H_TOTAL, V_TOTAL)
  - COORD_W = 10
  - screen-edge constants shared with ball and paddle logic
- Sub-module pix_clk_en:
  - parameter CLK_DIV; ports clk, reset_n, pix_tick
  - isolates the divider so renderers can reuse it.
- The counter and sync decode stay in vga_timing.

Test Plan:
- Reset: hold reset_n low 5 clks, then release -> hcount=0, vcount=0, hsync=vsync=1, video_on=0, frame_tick=0 while low. First pix_tick arrives 2 clks after release and hcount reaches 1 there.
- Line wrap: run to hcount 799, vcount 10 -> next pix_tick gives hcount 0, vcount 11. The hsync low window covers hcount 656..751 (96 pixels = 192 clks); video_on falls at hcount 640.
- Frame wrap: vcount 524, hcount 799 -> next pix_tick gives (0,0) with video_on=1. vsync is low exactly for vcount 490..491 (1600 pixels).
- frame_tick: measure across 3 frames -> one pulse per frame, 1 clk wide, 840000 clks apart, aligned with the vsync falling edge at (0,490).
- Mid-frame reset: assert reset_n low at (300,200) -> all outputs reset within the same clk. After release, the next frame_tick occurs 490*800*2 clks later.
- CLK_DIV=1 with VGA_FRAME_COUNT_EN:
  - pix_tick is constant 1 and the frame period is 420000 clks.
  - frame_count reaches 3 after 3 frames.
  - Forcing frame_count to 0xFFFF wraps it to 0 on the next frame_tick.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants for the Pong display pipeline: default 640x480 raster
// timing, coordinate width, screen-edge positions used by the ball and
// paddle logic, and a small window-decode helper used by the sync decode.
package pong_pkg;

  localparam int COORD_W = 10;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Playfield edges in pixel coordinates (inclusive).
  localparam logic [COORD_W-1:0] SCREEN_LEFT   = 10'd0;
  localparam logic [COORD_W-1:0] SCREEN_RIGHT  = 10'd639;
  localparam logic [COORD_W-1:0] SCREEN_TOP    = 10'd0;
  localparam logic [COORD_W-1:0] SCREEN_BOTTOM = 10'd479;

  // True when lo <= v < lo + len.
  function automatic logic in_window(input logic [COORD_W-1:0] v,
                                     input int lo, input int len);
    int vi;
    vi = int'(v);
    return (vi >= lo) && (vi < (lo + len));
  endfunction

endpackage

// File: rtl/pix_clk_en.sv
// Pixel clock-enable generator: divides the system clock by CLK_DIV and
// emits a one-clk registered enable once per pixel period. Kept separate
// so the renderers can reuse the same divider.
module pix_clk_en #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic pix_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_div_check
    $error("pix_clk_en: CLK_DIV must be >= 1");
  end

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pix_tick_q, pix_tick_d;

  // Next divider count and registered enable aligned with the last count.
  always_comb begin
    div_cnt_d  = div_cnt_q;
    pix_tick_d = 1'b0;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
    pix_tick_d = (div_cnt_d == DIV_LAST);
  end

  // Divider state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q  <= '0;
      pix_tick_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      pix_tick_q <= pix_tick_d;
    end
  end

  assign pix_tick = pix_tick_q;

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: pixel/line counters, hsync/vsync, active-video
// flag and a per-frame tick. All outputs are registered and decoded from
// the next-state counters so they line up with hcount/vcount exactly.
// Optional build macro VGA_FRAME_COUNT_EN adds a 16-bit frame counter.
module vga_timing
  import pong_pkg::*;
#(
  parameter int   CLK_DIV     = 2,
  parameter int   H_ACTIVE    = pong_pkg::H_ACTIVE,
  parameter int   H_FP        = pong_pkg::H_FP,
  parameter int   H_SYNC      = pong_pkg::H_SYNC,
  parameter int   H_BP        = pong_pkg::H_BP,
  parameter int   V_ACTIVE    = pong_pkg::V_ACTIVE,
  parameter int   V_FP        = pong_pkg::V_FP,
  parameter int   V_SYNC      = pong_pkg::V_SYNC,
  parameter int   V_BP        = pong_pkg::V_BP,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               pix_tick,
  output logic [COORD_W-1:0] hcount,
  output logic [COORD_W-1:0] vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               frame_tick
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0]        frame_count
`endif
);

  localparam int LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(LINE_LEN - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(FRAME_LINES - 1);

  if (((LINE_LEN - 1) >= (1 << COORD_W)) || ((FRAME_LINES - 1) >= (1 << COORD_W))) begin : g_width_check
    $error("vga_timing: total line or frame length does not fit in COORD_W bits");
  end

  logic               pix_tick_s;
  logic [COORD_W-1:0] hcount_q, hcount_d;
  logic [COORD_W-1:0] vcount_q, vcount_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               video_on_q, video_on_d;
  logic               frame_tick_q, frame_tick_d;

  pix_clk_en #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_clk_en (
    .clk      (clk),
    .reset_n  (reset_n),
    .pix_tick (pix_tick_s)
  );

  // Pixel/line counters, advancing once per pixel period.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_tick_s) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        if (vcount_q == V_LAST) begin
          vcount_d = '0;
        end else begin
          vcount_d = vcount_q + 1'b1;
        end
      end else begin
        hcount_d = hcount_q + 1'b1;
        vcount_d = vcount_q;
      end
    end else begin
      hcount_d = hcount_q;
      vcount_d = vcount_q;
    end
  end

  // Sync/video decode from the next-state counters; holds between pixels.
  always_comb begin
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    video_on_d   = video_on_q;
    frame_tick_d = 1'b0;
    if (pix_tick_s) begin
      hsync_d      = in_window(hcount_d, H_ACTIVE + H_FP, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_d      = in_window(vcount_d, V_ACTIVE + V_FP, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      video_on_d   = in_window(hcount_d, 0, H_ACTIVE) && in_window(vcount_d, 0, V_ACTIVE);
      frame_tick_d = (vsync_d == SYNC_ACTIVE) && (vsync_q != SYNC_ACTIVE);
    end else begin
      frame_tick_d = 1'b0;
    end
  end

  // Counter and decoded-output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q     <= '0;
      vcount_q     <= '0;
      hsync_q      <= ~SYNC_ACTIVE;
      vsync_q      <= ~SYNC_ACTIVE;
      video_on_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      hcount_q     <= hcount_d;
      vcount_q     <= vcount_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      video_on_q   <= video_on_d;
      frame_tick_q <= frame_tick_d;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  // Frame counter bumps in the same clk as frame_tick and wraps naturally.
  always_comb begin
    frame_count_d = frame_count_q;
    if (frame_tick_d) begin
      frame_count_d = frame_count_q + 16'd1;
    end else begin
      frame_count_d = frame_count_q;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_q <= 16'd0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`endif

  assign pix_tick   = pix_tick_s;
  assign hcount     = hcount_q;
  assign vcount     = vcount_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = video_on_q;
  assign frame_tick = frame_tick_q;

endmodule
